// File: rtl/gpr_dbg_access_pkg.sv
// rtl/gpr_dbg_access_pkg.sv - shared GPR bus widths and debug-access FSM encodings
package gpr_dbg_access_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegBus     = 32;

    typedef logic [RegAddrBus-1:0] reg_addr_t;
    typedef logic [RegBus-1:0]     reg_data_t;

    // Encodings are fixed so the debug module can decode busy context.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } dbg_state_e;

endpackage

// File: rtl/gpr_dbg_access.sv
// rtl/gpr_dbg_access.sv - debug read/burst-read/write engine for the GPR file (write path: DBG_GPR_WRITE_EN)
module gpr_dbg_access
    import gpr_dbg_access_pkg::*;
#(
    parameter int BURST_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dbg_req_i,
    output logic               dbg_ready_o,
    input  logic               dbg_we_i,
    input  logic [4:0]         dbg_addr_i,
    input  logic [BURST_W-1:0] dbg_len_i,
    input  logic [31:0]        dbg_wdata_i,
    output logic               dbg_rvalid_o,
    input  logic               dbg_rready_i,
    output logic [31:0]        dbg_rdata_o,
    output logic               dbg_err_o,
    output logic               dbg_busy_o,
    input  logic               core_halted_i,
    output logic [4:0]         bus_raddr_o,
    input  logic [31:0]        bus_data_i,
    input  logic               core_we_i,
    output logic               reg_we_o,
    output logic [4:0]         reg_waddr_o,
    output logic [31:0]        reg_wdata_o
);

`ifdef DBG_GPR_WRITE_EN
    localparam logic WrDisabled = 1'b0;
    reg_data_t wdata_q;
`else
    localparam logic WrDisabled = 1'b1;
    logic unused_wr;
    assign unused_wr = ^{dbg_wdata_i, core_we_i};
`endif

    dbg_state_e         state_q;
    dbg_state_e         state_d;
    reg_addr_t          addr_q;
    logic [BURST_W-1:0] beats_q;
    reg_data_t          rdata_q;
    logic               err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dbg_req_i) begin
                    if (!core_halted_i) begin
                        state_d = ST_RESP;
                    end else if (dbg_we_i) begin
`ifdef DBG_GPR_WRITE_EN
                        state_d = ST_WRITE;
`else
                        state_d = ST_RESP;
`endif
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: state_d = ST_RESP;
            ST_WRITE: begin
`ifdef DBG_GPR_WRITE_EN
                // The core write port always wins; wait for a free cycle.
                if (!core_we_i) begin
                    state_d = ST_RESP;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RESP: begin
                if (dbg_rready_i) begin
                    state_d = (beats_q != '0) ? ST_READ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            beats_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DBG_GPR_WRITE_EN
            wdata_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dbg_req_i) begin
                        addr_q  <= dbg_addr_i;
                        beats_q <= '0;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
`ifdef DBG_GPR_WRITE_EN
                        wdata_q <= dbg_wdata_i;
`endif
                        if (!core_halted_i) begin
                            err_q <= 1'b1;
                        end else if (dbg_we_i) begin
                            err_q <= WrDisabled;
                        end else begin
                            beats_q <= dbg_len_i;
                        end
                    end
                end
                ST_READ: begin
                    if (core_halted_i) begin
                        rdata_q <= (addr_q == '0) ? '0 : bus_data_i;
                        err_q   <= 1'b0;
                    end else begin
                        // Losing halt mid-burst ends the burst after this error beat.
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        beats_q <= '0;
                    end
                end
`ifdef DBG_GPR_WRITE_EN
                ST_WRITE: begin
                    if (!core_we_i) begin
                        rdata_q <= '0;
                        err_q   <= (addr_q == '0);
                    end
                end
`endif
                ST_RESP: begin
                    if (dbg_rready_i && (beats_q != '0)) begin
                        beats_q <= beats_q - {{(BURST_W-1){1'b0}}, 1'b1};
                        addr_q  <= addr_q + reg_addr_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dbg_ready_o  = (state_q == ST_IDLE);
        dbg_busy_o   = (state_q != ST_IDLE);
        dbg_rvalid_o = (state_q == ST_RESP);
        dbg_rdata_o  = (state_q == ST_RESP) ? rdata_q : '0;
        dbg_err_o    = (state_q == ST_RESP) && err_q;
        bus_raddr_o  = (state_q == ST_READ) ? addr_q : '0;
`ifdef DBG_GPR_WRITE_EN
        reg_we_o     = (state_q == ST_WRITE) && !core_we_i && (addr_q != '0);
        reg_waddr_o  = reg_we_o ? addr_q : '0;
        reg_wdata_o  = reg_we_o ? wdata_q : '0;
`else
        reg_we_o     = 1'b0;
        reg_waddr_o  = '0;
        reg_wdata_o  = '0;
`endif
    end

endmodule

// File: tb/tb_gpr_dbg_access.sv
// tb/tb_gpr_dbg_access.sv - self-checking bench for gpr_dbg_access
module tb_gpr_dbg_access;

    logic        clk;
    logic        rst_n;
    logic        dbg_req_i;
    logic        dbg_ready_o;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [4:0]  dbg_len_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_rvalid_o;
    logic        dbg_rready_i;
    logic [31:0] dbg_rdata_o;
    logic        dbg_err_o;
    logic        dbg_busy_o;
    logic        core_halted_i;
    logic [4:0]  bus_raddr_o;
    logic [31:0] bus_data_i;
    logic        core_we_i;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    gpr_dbg_access #(.BURST_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_req_i(dbg_req_i), .dbg_ready_o(dbg_ready_o), .dbg_we_i(dbg_we_i),
        .dbg_addr_i(dbg_addr_i), .dbg_len_i(dbg_len_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_rvalid_o(dbg_rvalid_o), .dbg_rready_i(dbg_rready_i), .dbg_rdata_o(dbg_rdata_o),
        .dbg_err_o(dbg_err_o), .dbg_busy_o(dbg_busy_o), .core_halted_i(core_halted_i),
        .bus_raddr_o(bus_raddr_o), .bus_data_i(bus_data_i), .core_we_i(core_we_i),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [4:0]  len;
        logic [31:0] wdata;
        logic        halted;
        logic        exp_err;
        int          exp_beats;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[10];
    logic [31:0] mem[32];
    logic [31:0] gold[32];
    logic        mem_load;
    int          n_checks = 0;
    int          n_fail = 0;
    int          resp_cnt = 0;
    int          we_pulses = 0;
    int          rr_mode = 0;
    logic        rready_man = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] seed(input int i);
        if (i == 0) return 32'd0;
        if (i == 5) return 32'h1234_5678;
        return 32'h9E37_0000 + i * 32'h0101_0011;
    endfunction

    // Register-file stand-in: combinational read port, debug write port.
    assign bus_data_i = (bus_raddr_o == 5'd0) ? 32'd0 : mem[bus_raddr_o];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= seed(i);
        end else if (reg_we_o) begin
            mem[reg_waddr_o] <= reg_wdata_o;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (rr_mode == 0) dbg_rready_i = 1'b1;
        else if (rr_mode == 1) dbg_rready_i = 1'($urandom_range(0, 1));
        else dbg_rready_i = rready_man;
    end

    // Response scoreboard and protocol monitors.
    always @(negedge clk) begin
        if (rst_n && dbg_rvalid_o) begin
            if (stall_prev) begin
                check("stable_rdata", dbg_rdata_o, held_rdata);
                check("stable_err", dbg_err_o, held_err);
            end
            if (dbg_rready_i) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_rdata", dbg_rdata_o, e.rdata);
                    check("resp_err", dbg_err_o, e.err);
                end
            end
        end
        if (reg_we_o) begin
            we_pulses++;
            check("reg_we_vs_core_we", core_we_i, 0);
        end
        stall_prev = rst_n && dbg_rvalid_o && !dbg_rready_i;
        held_rdata = dbg_rdata_o;
        held_err   = dbg_err_o;
    end

    task automatic send_cmd(input logic we, input logic [4:0] addr, input logic [4:0] len,
                            input logic [31:0] wdata);
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (dbg_ready_o) begin
                ok = 1;
                break;
            end
        end
        check("ready_timeout", ok, 1);
        dbg_req_i   = 1'b1;
        dbg_we_i    = we;
        dbg_addr_i  = addr;
        dbg_len_i   = len;
        dbg_wdata_i = wdata;
        @(posedge clk);
        #1 dbg_req_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && dbg_ready_o) begin
                done = 1;
                break;
            end
        end
        check("idle_timeout", done, 1);
    endtask

    task automatic wait_rvalid();
        bit seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dbg_rvalid_o) begin
                seen = 1;
                break;
            end
        end
        check("rvalid_timeout", seen, 1);
    endtask

    task automatic push_expect(input vec_t v);
        exp_t e;
        if (v.exp_err) begin
            e.rdata = 32'd0; e.err = 1'b1; sb.push_back(e);
        end else if (v.we) begin
            e.rdata = 32'd0; e.err = 1'b0; sb.push_back(e);
            gold[v.addr] = v.wdata;
        end else begin
            for (int i = 0; i < v.exp_beats; i++) begin
                e.rdata = gold[5'(int'(v.addr) + i)];
                e.err   = 1'b0;
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;
        int   cnt0;
        int   p0;
        rst_n = 1'b0; mem_load = 1'b1;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_len_i = 0; dbg_wdata_i = 0;
        dbg_rready_i = 1'b1; core_halted_i = 1'b1; core_we_i = 1'b0;
        for (int i = 0; i < 32; i++) gold[i] = seed(i);

        vecs[0] = '{1'b0, 5'd5,  5'd0,  32'd0,          1'b1, 1'b0, 1};
        vecs[1] = '{1'b0, 5'd30, 5'd3,  32'd0,          1'b1, 1'b0, 4};
        vecs[2] = '{1'b0, 5'd0,  5'd0,  32'd0,          1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 5'd12, 5'd0,  32'd0,          1'b0, 1'b1, 1};
`ifdef DBG_GPR_WRITE_EN
        vecs[4] = '{1'b1, 5'd3,  5'd0,  32'hCAFE_F00D,  1'b1, 1'b0, 1};
`else
        vecs[4] = '{1'b1, 5'd3,  5'd0,  32'hCAFE_F00D,  1'b1, 1'b1, 1};
`endif
        vecs[5] = '{1'b1, 5'd0,  5'd0,  32'h0000_1111,  1'b1, 1'b1, 1};
        vecs[6] = '{1'b0, 5'd3,  5'd0,  32'd0,          1'b1, 1'b0, 1};
        vecs[7] = '{1'b0, 5'd31, 5'd31, 32'd0,          1'b1, 1'b0, 32};
        vecs[8] = '{1'b1, 5'd9,  5'd3,  32'h5555_AAAA,  1'b0, 1'b1, 1};
        vecs[9] = '{1'b0, 5'd8,  5'd5,  32'd0,          1'b0, 1'b1, 1};

        repeat (3) @(negedge clk);
        check("rst_ready", dbg_ready_o, 1);
        check("rst_busy", dbg_busy_o, 0);
        check("rst_rvalid", dbg_rvalid_o, 0);
        check("rst_rdata", dbg_rdata_o, 0);
        check("rst_err", dbg_err_o, 0);
        check("rst_raddr", bus_raddr_o, 0);
        check("rst_reg_we", reg_we_o, 0);
        check("rst_waddr", reg_waddr_o, 0);
        check("rst_wdata", reg_wdata_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mem_load = 1'b0;

        rr_mode = 1;
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            core_halted_i = v.halted;
            cnt0 = resp_cnt;
            push_expect(v);
            send_cmd(v.we, v.addr, v.len, v.wdata);
            if (!v.we) begin
                @(negedge clk);
                check("raddr_t1", bus_raddr_o, v.halted ? v.addr : 5'd0);
                if (v.halted) begin
                    check("rvalid_t1", dbg_rvalid_o, 0);
                    check("busy_t1", dbg_busy_o, 1);
                    @(negedge clk);
                    check("rvalid_t2", dbg_rvalid_o, 1);
                end
            end
            wait_idle();
            check("beat_count", resp_cnt - cnt0, v.exp_beats);
            core_halted_i = 1'b1;
        end

        // Halt drops mid-burst: second beat errors and ends the burst.
        rr_mode = 2; rready_man = 1'b0;
        cnt0 = resp_cnt;
        e.rdata = gold[2]; e.err = 1'b0; sb.push_back(e);
        e.rdata = 32'd0;   e.err = 1'b1; sb.push_back(e);
        send_cmd(1'b0, 5'd2, 5'd3, 32'd0);
        wait_rvalid();
        @(posedge clk);
        #1 core_halted_i = 1'b0; rready_man = 1'b1;
        wait_idle();
        check("halt_drop_beats", resp_cnt - cnt0, 2);
        core_halted_i = 1'b1; rready_man = 1'b0;

`ifdef DBG_GPR_WRITE_EN
        // Write stalled by the core write port for three cycles.
        rr_mode = 0;
        core_we_i = 1'b1;
        p0 = we_pulses;
        e.rdata = 32'd0; e.err = 1'b0; sb.push_back(e);
        gold[7] = 32'hDEAD_BEEF;
        send_cmd(1'b1, 5'd7, 5'd0, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("we_stalled", reg_we_o, 0);
        end
        @(posedge clk);
        #1 core_we_i = 1'b0;
        @(negedge clk);
        check("we_pulse", reg_we_o, 1);
        check("we_addr", reg_waddr_o, 7);
        check("we_data", reg_wdata_o, 32'hDEAD_BEEF);
        wait_idle();
        check("we_pulse_count", we_pulses - p0, 1);
        e.rdata = gold[7]; e.err = 1'b0; sb.push_back(e);
        send_cmd(1'b0, 5'd7, 5'd0, 32'd0);
        wait_idle();
        rr_mode = 2;
`endif

        // Reset during the second beat of a four-beat burst.
        rready_man = 1'b0;
        cnt0 = resp_cnt;
        e.rdata = gold[10]; e.err = 1'b0; sb.push_back(e);
        send_cmd(1'b0, 5'd10, 5'd3, 32'd0);
        wait_rvalid();
        @(posedge clk);
        #1 rready_man = 1'b1;
        @(posedge clk);
        #1 rready_man = 1'b0;
        wait_rvalid();
        #1 rst_n = 1'b0;
        #1;
        check("arst_rvalid", dbg_rvalid_o, 0);
        check("arst_ready", dbg_ready_o, 1);
        check("arst_busy", dbg_busy_o, 0);
        check("arst_reg_we", reg_we_o, 0);
        check("arst_sb_empty", sb.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rr_mode = 0;
        repeat (10) @(negedge clk);
        check("arst_no_more_beats", resp_cnt - cnt0, 1);
        check("arst_idle", dbg_ready_o, 1);

`ifdef DBG_GPR_WRITE_EN
        check("total_we_pulses", we_pulses, 2);
`else
        check("total_we_pulses", we_pulses, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
